key_event: RTL and testbench

Converts the clean, debounced button level from the debouncer into discrete user events: a single-cycle press pulse, a release pulse, a long-press pulse, and an auto-repeat pulse train while the button stays held. It sits between the debouncer output and the counter/scan logic in the counter_scan design. It supplies a combined `step` strobe so the counter advances once per press and repeatedly while the button is held.

---
 rtl/key_event_if.sv | 12 +
 rtl/key_event.sv | 66 ++++++
 tb/tb_key_event.sv | 99 +++++++++
 3 files changed

// File: rtl/key_event_if.sv
// key_event_if: debounced button level in, registered key events out.
interface key_event_if;
  logic btn;
  logic press;
  logic release_evt;
  logic long;
  logic repeat_evt;
  logic step;
  logic held;
  modport master(output btn, input press, release_evt, long, repeat_evt, step, held);
  modport slave(input btn, output press, release_evt, long, repeat_evt, step, held);
endinterface

// File: rtl/key_event.sv
// key_event: turns a debounced button level into press/release/long/repeat pulses and a step strobe.
module key_event #(
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000,
  parameter int CNT_W         = 25
) (
  input logic         clk,
  input logic         clr_n,
  key_event_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, PRESSED, REPEAT} state_t;
  localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_END  = CNT_W'(REPEAT_CYCLES - 1);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic press_n, rel_n, long_n, rep_n;
  // a low btn on a long/repeat boundary edge releases instead of firing the event
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    press_n = 1'b0;
    rel_n   = 1'b0;
    long_n  = 1'b0;
    rep_n   = 1'b0;
    case (state)
      IDLE: begin
        state_n = bus.btn ? PRESSED : IDLE;
        cnt_n   = {{(CNT_W-1){1'b0}}, bus.btn};
        press_n = bus.btn;
      end
      PRESSED: begin
        state_n = !bus.btn ? IDLE : (cnt == HOLD_END) ? REPEAT : PRESSED;
        cnt_n   = (!bus.btn || cnt == HOLD_END) ? '0 : cnt + 1'b1;
        rel_n   = !bus.btn;
        long_n  = bus.btn && cnt == HOLD_END;
      end
      default: begin
        state_n = bus.btn ? REPEAT : IDLE;
        cnt_n   = (!bus.btn || cnt == REP_END) ? '0 : cnt + 1'b1;
        rel_n   = !bus.btn;
        rep_n   = bus.btn && cnt == REP_END;
      end
    endcase
  end
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state           <= IDLE;
      cnt             <= '0;
      bus.press       <= 1'b0;
      bus.release_evt <= 1'b0;
      bus.long        <= 1'b0;
      bus.repeat_evt  <= 1'b0;
      bus.step        <= 1'b0;
      bus.held        <= 1'b0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      bus.press       <= press_n;
      bus.release_evt <= rel_n;
      bus.long        <= long_n;
      bus.repeat_evt  <= rep_n;
      bus.step        <= press_n | rep_n;
      bus.held        <= state_n != IDLE;
    end
  end
endmodule

// File: tb/tb_key_event.sv
// tb_key_event: directed checks of key_event with HOLD_CYCLES=8, REPEAT_CYCLES=3.
module tb_key_event;
  localparam int HOLD = 8;
  localparam int REP  = 3;
  logic clk = 1'b0;
  logic clr_n;
  int errors = 0;
  int checks = 0;
  int steps = 0;
  key_event_if ki();
  key_event #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .CNT_W(4)) dut (
    .clk(clk),
    .clr_n(clr_n),
    .bus(ki.slave)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // expected vector order: {press, release, long, repeat, step, held}
  task automatic chk(string tag, logic [5:0] exp);
    logic [5:0] obs;
    obs = {ki.press, ki.release_evt, ki.long, ki.repeat_evt, ki.step, ki.held};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  // hold btn high for edges t0..t1, counting t from the pressing edge E0 = 1
  task automatic hold(int t0, int t1);
    logic p, l, r;
    ki.btn = 1'b1;
    for (int t = t0; t <= t1; t++) begin
      tick();
      p = (t == 1);
      l = (t == HOLD);
      r = (t > HOLD) && ((t - HOLD) % REP == 0);
      chk($sformatf("hold t=%0d", t), {p, 1'b0, l, r, p | r, 1'b1});
      steps += int'(p | r);
    end
  endtask
  task automatic drop();
    ki.btn = 1'b0;
    tick();
    chk("release", 6'b010000);
    tick();
    chk("idle after release", 6'b000000);
  endtask
  initial begin
    clr_n = 1'b1;
    ki.btn = 1'b0;
    #1 clr_n = 1'b0;
    #1 chk("reset async", 6'b000000);
    tick();
    tick();
    chk("reset held", 6'b000000);
    clr_n = 1'b1;
    tick();
    chk("idle", 6'b000000);
    hold(1, 4);
    drop();
    hold(1, 20);
    drop();
    hold(1, HOLD - 1);
    drop();
    hold(1, HOLD + REP - 1);
    drop();
    ki.btn = 1'b1;
    tick();
    chk("min press k", 6'b100011);
    ki.btn = 1'b0;
    tick();
    chk("min release k+1", 6'b010000);
    ki.btn = 1'b1;
    tick();
    chk("re-press k+2", 6'b100011);
    drop();
    hold(1, 12);
    clr_n = 1'b0;
    #1 chk("reset in repeat", 6'b000000);
    tick();
    chk("reset no release", 6'b000000);
    clr_n = 1'b1;
    hold(1, 2);
    drop();
    steps = 0;
    hold(1, HOLD + 5 * REP);
    checks++;
    assert (steps == 6) else begin
      errors++;
      $error("FAIL step count: observed=%0d expected=6", steps);
    end
    drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
